// File: rtl/axi_slave_resp_pop_ctrl_pkg.sv
// axi_slave_resp_pop_ctrl_pkg: shared widths, descriptor struct and R pop FSM states
package axi_slave_resp_pop_ctrl_pkg;
   localparam int DATA_W_DEF = 256;
   localparam int ID_W_DEF   = 4;
   localparam int LEN_W_DEF  = 8;
   localparam int RESP_W_DEF = 2;
   typedef enum logic {IDLE, BURST} r_pop_state_e;
   typedef struct packed {
      logic [ID_W_DEF-1:0]   id;
      logic [LEN_W_DEF-1:0]  len;
      logic [RESP_W_DEF-1:0] resp;
   } rd_desc_t;
endpackage

// File: rtl/axi_slave_resp_pop_ctrl_b_resp_pop.sv
// b_resp_pop: B-channel output register fed by the write-response FIFO
module b_resp_pop #(
   parameter int ID_W   = 4,
   parameter int RESP_W = 2
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              wr_resp_empty,
   input  logic [ID_W-1:0]   wr_resp_id,
   input  logic [RESP_W-1:0] wr_resp_code,
   output logic              wr_resp_pop,
   output logic [ID_W-1:0]   BID,
   output logic [RESP_W-1:0] BRESP,
   output logic              BVALID,
   input  logic              BREADY
);
   always_comb wr_resp_pop = !arst && !wr_resp_empty && (!BVALID || BREADY);
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         BID    <= '0;
         BRESP  <= '0;
         BVALID <= 1'b0;
      end else if (wr_resp_pop) begin
         BID    <= wr_resp_id;
         BRESP  <= wr_resp_code;
         BVALID <= 1'b1;
      end else if (BREADY) begin
         BVALID <= 1'b0;
      end
   end
endmodule

// File: rtl/axi_slave_resp_pop_ctrl.sv
// axi_slave_resp_pop_ctrl: drains read descriptors/data into R bursts and write responses into B
module axi_slave_resp_pop_ctrl
   import axi_slave_resp_pop_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int RESP_W = RESP_W_DEF
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              rd_desc_empty,
   input  logic [ID_W-1:0]   rd_desc_id,
   input  logic [LEN_W-1:0]  rd_desc_len,
   input  logic [RESP_W-1:0] rd_desc_resp,
   output logic              rd_desc_pop,
   input  logic              rd_data_empty,
   input  logic [DATA_W-1:0] rd_data,
   output logic              rd_data_pop,
   input  logic              wr_resp_empty,
   input  logic [ID_W-1:0]   wr_resp_id,
   input  logic [RESP_W-1:0] wr_resp_code,
   output logic              wr_resp_pop,
   output logic [ID_W-1:0]   RID,
   output logic [DATA_W-1:0] RDATA,
   output logic [RESP_W-1:0] RRESP,
   output logic              RLAST,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [ID_W-1:0]   BID,
   output logic [RESP_W-1:0] BRESP,
   output logic              BVALID,
   input  logic              BREADY
);
   r_pop_state_e      state, state_n;
   logic              load, last;
   logic [LEN_W-1:0]  beat_cnt, cur_len;
   logic [ID_W-1:0]   cur_id;
   logic [RESP_W-1:0] cur_resp;

   // pops are gated by reset so nothing is consumed while the FIFOs flush
   always_comb begin
      rd_desc_pop = !arst && state == IDLE && !rd_desc_empty;
      load        = !arst && state == BURST && !rd_data_empty && (!RVALID || RREADY);
      rd_data_pop = load;
      last        = beat_cnt == cur_len;
      state_n     = rd_desc_pop ? BURST : (load && last) ? IDLE : state;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         cur_id   <= '0;
         cur_len  <= '0;
         cur_resp <= '0;
         RID      <= '0;
         RDATA    <= '0;
         RRESP    <= '0;
         RLAST    <= 1'b0;
         RVALID   <= 1'b0;
      end else begin
         state <= state_n;
         if (rd_desc_pop) begin
            cur_id   <= rd_desc_id;
            cur_len  <= rd_desc_len;
            cur_resp <= rd_desc_resp;
            beat_cnt <= '0;
         end
         if (load) begin
            RDATA    <= rd_data;
            RID      <= cur_id;
            RRESP    <= cur_resp;
            RVALID   <= 1'b1;
            RLAST    <= last;
            beat_cnt <= beat_cnt + 1'b1;
         end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
         end
      end
   end

   b_resp_pop #(.ID_W(ID_W), .RESP_W(RESP_W)) u_b (
      .clk          (clk),
      .arst         (arst),
      .wr_resp_empty(wr_resp_empty),
      .wr_resp_id   (wr_resp_id),
      .wr_resp_code (wr_resp_code),
      .wr_resp_pop  (wr_resp_pop),
      .BID          (BID),
      .BRESP        (BRESP),
      .BVALID       (BVALID),
      .BREADY       (BREADY)
   );
endmodule

// File: tb/tb_axi_slave_resp_pop_ctrl.sv
// tb_axi_slave_resp_pop_ctrl: directed bench with FIFO models and R/B handshake logs
module tb_axi_slave_resp_pop_ctrl;
   import axi_slave_resp_pop_ctrl_pkg::*;

   typedef struct {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; int cyc;} rbeat_t;
   typedef struct {logic [3:0] id; logic [1:0] resp; int cyc;} bbeat_t;
   typedef struct {logic [3:0] id; logic [1:0] resp;} wresp_t;

   logic         clk = 0, arst = 1;
   logic         rd_desc_empty = 1, rd_data_empty = 1, wr_resp_empty = 1;
   logic [3:0]   rd_desc_id = 0, wr_resp_id = 0, RID, BID;
   logic [7:0]   rd_desc_len = 0;
   logic [1:0]   rd_desc_resp = 0, wr_resp_code = 0, RRESP, BRESP;
   logic [255:0] rd_data = 0, RDATA;
   logic         rd_desc_pop, rd_data_pop, wr_resp_pop;
   logic         RLAST, RVALID, BVALID, RREADY = 0, BREADY = 0;

   rd_desc_t     dq[$];
   logic [255:0] rq[$];
   wresp_t       wq[$];
   rbeat_t       rlog[$];
   bbeat_t       blog[$];
   int           n_tests = 0, n_fail = 0, cyc = 0, n_dpop = 0;
   logic         stall_prev = 0;
   logic [63:0]  sv_data;
   logic [3:0]   sv_id;
   logic         sv_last;
   logic         found;

   always #5 clk = ~clk;

   axi_slave_resp_pop_ctrl dut (
      .clk(clk), .arst(arst),
      .rd_desc_empty(rd_desc_empty), .rd_desc_id(rd_desc_id), .rd_desc_len(rd_desc_len),
      .rd_desc_resp(rd_desc_resp), .rd_desc_pop(rd_desc_pop),
      .rd_data_empty(rd_data_empty), .rd_data(rd_data), .rd_data_pop(rd_data_pop),
      .wr_resp_empty(wr_resp_empty), .wr_resp_id(wr_resp_id), .wr_resp_code(wr_resp_code),
      .wr_resp_pop(wr_resp_pop),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      rd_desc_empty = dq.size() == 0;
      if (dq.size() > 0) begin
         rd_desc_id   = dq[0].id;
         rd_desc_len  = dq[0].len;
         rd_desc_resp = dq[0].resp;
      end
      rd_data_empty = rq.size() == 0;
      if (rq.size() > 0) rd_data = rq[0];
      wr_resp_empty = wq.size() == 0;
      if (wq.size() > 0) begin
         wr_resp_id   = wq[0].id;
         wr_resp_code = wq[0].resp;
      end
   endtask

   task automatic sync();
      refresh();
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      sync();
   endtask

   // FIFO models, handshake logs and R stall-stability checks
   always @(posedge clk) begin
      cyc++;
      if (stall_prev) begin
         chk("r_stall_valid", 64'(RVALID), 64'd1);
         chk("r_stall_data", RDATA[63:0], sv_data);
         chk("r_stall_id", 64'(RID), 64'(sv_id));
         chk("r_stall_last", 64'(RLAST), 64'(sv_last));
      end
      stall_prev = RVALID && !RREADY && !arst;
      sv_data = RDATA[63:0];
      sv_id = RID;
      sv_last = RLAST;
      if (rd_desc_pop && dq.size() > 0) void'(dq.pop_front());
      if (rd_data_pop && rq.size() > 0) begin
         void'(rq.pop_front());
         n_dpop++;
      end
      if (wr_resp_pop && wq.size() > 0) void'(wq.pop_front());
      if (RVALID && RREADY) rlog.push_back('{RID, RDATA[63:0], RRESP, RLAST, cyc});
      if (BVALID && BREADY) blog.push_back('{BID, BRESP, cyc});
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      repeat (2) tick();
      chk("rst_rvalid", 64'(RVALID), 0);
      chk("rst_rlast", 64'(RLAST), 0);
      chk("rst_rid", 64'(RID), 0);
      chk("rst_rdata", RDATA[63:0], 0);
      chk("rst_rresp", 64'(RRESP), 0);
      chk("rst_bvalid", 64'(BVALID), 0);
      chk("rst_bid", 64'(BID), 0);
      chk("rst_bresp", 64'(BRESP), 0);
      dq.push_back('{4'd1, 8'd0, 2'd0});
      wq.push_back('{4'd1, 2'd0});
      sync();
      chk("rst_desc_pop", 64'(rd_desc_pop), 0);
      chk("rst_wr_pop", 64'(wr_resp_pop), 0);
      dq.delete();
      wq.delete();
      tick();
      arst = 0;
      tick();

      // single-beat read
      dq.push_back('{4'd3, 8'd0, 2'd0});
      rq.push_back(256'hA5);
      RREADY = 1;
      sync();
      chk("t1_desc_pop", 64'(rd_desc_pop), 1);
      chk("t1_idle_no_data_pop", 64'(rd_data_pop), 0);
      tick();
      chk("t1_desc_pop_once", 64'(rd_desc_pop), 0);
      chk("t1_data_pop", 64'(rd_data_pop), 1);
      chk("t1_rvalid_t1", 64'(RVALID), 0);
      tick();
      chk("t1_rvalid_t2", 64'(RVALID), 1);
      chk("t1_rid", 64'(RID), 3);
      chk("t1_rdata", RDATA[63:0], 64'hA5);
      chk("t1_rlast", 64'(RLAST), 1);
      chk("t1_rresp", 64'(RRESP), 0);
      tick();
      chk("t1_rvalid_drop", 64'(RVALID), 0);
      chk("t1_rlast_drop", 64'(RLAST), 0);

      // 4-beat burst under backpressure
      rlog.delete();
      n_dpop = 0;
      dq.push_back('{4'd1, 8'd3, 2'd1});
      for (int i = 1; i <= 4; i++) rq.push_back(256'(i));
      for (int i = 0; i < 20; i++) begin
         RREADY = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end
      RREADY = 1;
      chk("t2_beats", 64'(rlog.size()), 4);
      chk("t2_data_pops", 64'(n_dpop), 4);
      for (int i = 0; i < rlog.size() && i < 4; i++) begin
         chk($sformatf("t2_data%0d", i), rlog[i].data, 64'(i + 1));
         chk($sformatf("t2_last%0d", i), 64'(rlog[i].last), 64'(i == 3));
         chk($sformatf("t2_id%0d", i), 64'(rlog[i].id), 1);
         chk($sformatf("t2_resp%0d", i), 64'(rlog[i].resp), 1);
      end

      // back-to-back bursts
      rlog.delete();
      dq.push_back('{4'd1, 8'd1, 2'd0});
      dq.push_back('{4'd2, 8'd2, 2'd0});
      for (int i = 0; i < 5; i++) rq.push_back(256'(10 + i));
      sync();
      repeat (12) tick();
      chk("t3_beats", 64'(rlog.size()), 5);
      if (rlog.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_data%0d", i), rlog[i].data, 64'(10 + i));
            chk($sformatf("t3_id%0d", i), 64'(rlog[i].id), (i < 2) ? 64'd1 : 64'd2);
            chk($sformatf("t3_last%0d", i), 64'(rlog[i].last), 64'(i == 1 || i == 4));
         end
         chk("t3_gap0", 64'(rlog[1].cyc - rlog[0].cyc), 1);
         chk("t3_bubble", 64'(rlog[2].cyc - rlog[1].cyc), 2);
         chk("t3_gap2", 64'(rlog[3].cyc - rlog[2].cyc), 1);
         chk("t3_gap3", 64'(rlog[4].cyc - rlog[3].cyc), 1);
      end

      // data underflow mid-burst
      rlog.delete();
      dq.push_back('{4'd4, 8'd3, 2'd2});
      rq.push_back(256'd20);
      rq.push_back(256'd21);
      sync();
      repeat (6) tick();
      chk("t4_partial_beats", 64'(rlog.size()), 2);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t4_rvalid_low%0d", i), 64'(RVALID), 0);
      end
      rq.push_back(256'd22);
      rq.push_back(256'd23);
      sync();
      repeat (6) tick();
      chk("t4_beats", 64'(rlog.size()), 4);
      for (int i = 0; i < rlog.size() && i < 4; i++) begin
         chk($sformatf("t4_data%0d", i), rlog[i].data, 64'(20 + i));
         chk($sformatf("t4_last%0d", i), 64'(rlog[i].last), 64'(i == 3));
         chk($sformatf("t4_resp%0d", i), 64'(rlog[i].resp), 2);
      end

      // B channel stall then stream, concurrent R burst
      rlog.delete();
      blog.delete();
      wq.push_back('{4'd5, 2'd0});
      wq.push_back('{4'd6, 2'd2});
      wq.push_back('{4'd7, 2'd3});
      dq.push_back('{4'd8, 8'd1, 2'd0});
      rq.push_back(256'd30);
      rq.push_back(256'd31);
      sync();
      chk("t5_wr_pop", 64'(wr_resp_pop), 1);
      tick();
      chk("t5_bvalid", 64'(BVALID), 1);
      chk("t5_bid", 64'(BID), 5);
      chk("t5_bresp", 64'(BRESP), 0);
      chk("t5_wr_pop_stalled", 64'(wr_resp_pop), 0);
      tick();
      chk("t5_bvalid_hold", 64'(BVALID), 1);
      chk("t5_bid_hold", 64'(BID), 5);
      BREADY = 1;
      repeat (6) tick();
      chk("t5_bcount", 64'(blog.size()), 3);
      if (blog.size() == 3) begin
         chk("t5_bid0", 64'(blog[0].id), 5);
         chk("t5_bid1", 64'(blog[1].id), 6);
         chk("t5_bid2", 64'(blog[2].id), 7);
         chk("t5_bresp1", 64'(blog[1].resp), 2);
         chk("t5_bresp2", 64'(blog[2].resp), 3);
         chk("t5_bgap", 64'(blog[2].cyc - blog[0].cyc), 2);
      end
      chk("t5_bvalid_end", 64'(BVALID), 0);
      chk("t5_rbeats", 64'(rlog.size()), 2);
      for (int i = 0; i < rlog.size() && i < 2; i++) begin
         chk($sformatf("t5_rid%0d", i), 64'(rlog[i].id), 8);
         chk($sformatf("t5_rdata%0d", i), rlog[i].data, 64'(30 + i));
         chk($sformatf("t5_rlast%0d", i), 64'(rlog[i].last), 64'(i == 1));
      end

      // reset mid-burst
      dq.push_back('{4'd9, 8'd3, 2'd1});
      for (int i = 0; i < 4; i++) rq.push_back(256'(40 + i));
      sync();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         found = RVALID && RDATA[63:0] == 64'd41;
      end
      chk("t6_reached_beat2", 64'(found), 1);
      arst = 1;
      dq.delete();
      rq.delete();
      wq.delete();
      sync();
      chk("t6_rvalid", 64'(RVALID), 0);
      chk("t6_rdata", RDATA[63:0], 0);
      chk("t6_rid", 64'(RID), 0);
      chk("t6_rlast", 64'(RLAST), 0);
      chk("t6_rresp", 64'(RRESP), 0);
      tick();
      arst = 0;
      rlog.delete();
      dq.push_back('{4'd10, 8'd1, 2'd3});
      rq.push_back(256'd50);
      rq.push_back(256'd51);
      sync();
      chk("t6_idle_desc_pop", 64'(rd_desc_pop), 1);
      repeat (6) tick();
      chk("t6_beats", 64'(rlog.size()), 2);
      for (int i = 0; i < rlog.size() && i < 2; i++) begin
         chk($sformatf("t6_data%0d", i), rlog[i].data, 64'(50 + i));
         chk($sformatf("t6_last%0d", i), 64'(rlog[i].last), 64'(i == 1));
         chk($sformatf("t6_id%0d", i), 64'(rlog[i].id), 10);
         chk($sformatf("t6_resp%0d", i), 64'(rlog[i].resp), 3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
